// File: rtl/prio_event_encoder.sv
// Registered priority event encoder: sticky pending bitmap feeding a valid/ready output stage.
// Optional PRIO_ENC_MASK_EN adds mask_in to exclude lines from selection without dropping their events.
module prio_event_encoder #(
  parameter int WIDTH      = 8,
  parameter bit HIGH_FIRST = 1'b1,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             clr_all,
  input  logic             out_ready,
`ifdef PRIO_ENC_MASK_EN
  input  logic [WIDTH-1:0] mask_in,
`endif
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);

  // Handshake: an event transfers on any edge where out_valid && out_ready.
  // out_valid/out_idx are held until that transfer (or clr_all).
  // out_ready only steers next state; it never reaches an output combinationally.

  logic             pop;
  logic             load;
  logic             ovf_hit;
  logic             win_any;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] clrbit;
  logic [WIDTH-1:0] pend_n;
  logic [WIDTH-1:0] elig;

  always_comb begin
    pop     = out_valid & out_ready & ~clr_all;
    clrbit  = pop ? (WIDTH'(1) << out_idx) : '0;
    pend_n  = clr_all ? req_in : ((pending & ~clrbit) | req_in);
    load    = ~out_valid | pop | clr_all;
    ovf_hit = |(req_in & pending & ~clrbit);
    // A load with a presented bit only happens on pop or clr_all, so the
    // presented bit never needs excluding from pend_n here.
`ifdef PRIO_ENC_MASK_EN
    elig    = pend_n & ~mask_in;
`else
    elig    = pend_n;
`endif
    win_any = |elig;
    win_idx = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (elig[i]) win_idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (elig[i]) win_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      overflow  <= 1'b0;
    end else begin
      pending  <= pend_n;
      overflow <= clr_all ? 1'b0 : (overflow | ovf_hit);
      if (load) begin
        out_valid <= win_any;
        out_idx   <= win_any ? win_idx : '0;
      end
    end
  end

endmodule
